// File: rtl/sync_parallel_counter_pkg.sv
// Shared definitions for the synchronous parallel up/down counter:
// update-mode encoding and default parameter values.
package sync_parallel_counter_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        INC  = 2'd2,
        DEC  = 2'd3
    } update_mode_t;

    localparam int DEFAULT_SIZE       = 4;
    localparam int DEFAULT_INIT_VALUE = 0;

endpackage

// File: rtl/sync_parallel_counter_next.sv
// Combinational next-state and wrap detection for sync_parallel_counter.
// Wrap-detect outputs exist only when SYNC_PARALLEL_COUNTER_FLAGS_EN is defined.
module sync_parallel_counter_next
    import sync_parallel_counter_pkg::*;
#(
    parameter int size = DEFAULT_SIZE
) (
    input  logic [size-1:0] value,
    input  logic            load,
    input  logic [size-1:0] load_value,
    input  logic            inc_enable,
    input  logic            dec_enable,
`ifdef SYNC_PARALLEL_COUNTER_FLAGS_EN
    output logic            wrap_up_next,
    output logic            wrap_down_next,
`endif
    output logic [size-1:0] value_next
);

    update_mode_t mode;

    // Load wins; opposing inc/dec requests cancel to a hold.
    always_comb begin
        mode = HOLD;
        if (load)
            mode = LOAD;
        else if (inc_enable && !dec_enable)
            mode = INC;
        else if (dec_enable && !inc_enable)
            mode = DEC;
    end

    always_comb begin
        value_next = value;
        case (mode)
            LOAD:    value_next = load_value;
            INC:     value_next = value + size'(1);
            DEC:     value_next = value - size'(1);
            default: value_next = value;
        endcase
    end

`ifdef SYNC_PARALLEL_COUNTER_FLAGS_EN
    assign wrap_up_next   = (mode == INC) && (value == {size{1'b1}});
    assign wrap_down_next = (mode == DEC) && (value == '0);
`endif

endmodule

// File: rtl/sync_parallel_counter.sv
// Synchronous parallel up/down counter with load; state and flag registers only.
// Define SYNC_PARALLEL_COUNTER_FLAGS_EN to add registered wrap_up/wrap_down outputs.
module sync_parallel_counter
    import sync_parallel_counter_pkg::*;
#(
    parameter int size       = DEFAULT_SIZE,
    parameter int init_value = DEFAULT_INIT_VALUE
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic [size-1:0] load_value,
    input  logic            inc_enable,
    input  logic            dec_enable,
`ifdef SYNC_PARALLEL_COUNTER_FLAGS_EN
    output logic            wrap_up,
    output logic            wrap_down,
`endif
    output logic [size-1:0] value
);

    localparam logic [size-1:0] INIT = size'(init_value);

    logic [size-1:0] value_reg;
    logic [size-1:0] value_next;

`ifdef SYNC_PARALLEL_COUNTER_FLAGS_EN
    logic wrap_up_reg;
    logic wrap_down_reg;
    logic wrap_up_next;
    logic wrap_down_next;
`endif

    sync_parallel_counter_next #(
        .size(size)
    ) u_next (
        .value          (value_reg),
        .load           (load),
        .load_value     (load_value),
        .inc_enable     (inc_enable),
        .dec_enable     (dec_enable),
`ifdef SYNC_PARALLEL_COUNTER_FLAGS_EN
        .wrap_up_next   (wrap_up_next),
        .wrap_down_next (wrap_down_next),
`endif
        .value_next     (value_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            value_reg <= INIT;
        else
            value_reg <= value_next;
    end

    assign value = value_reg;

`ifdef SYNC_PARALLEL_COUNTER_FLAGS_EN
    // Flags are one-cycle pulses describing the edge that just happened.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrap_up_reg   <= 1'b0;
            wrap_down_reg <= 1'b0;
        end else begin
            wrap_up_reg   <= wrap_up_next;
            wrap_down_reg <= wrap_down_next;
        end
    end

    assign wrap_up   = wrap_up_reg;
    assign wrap_down = wrap_down_reg;
`endif

endmodule

// File: tb/tb_sync_parallel_counter.sv
// Self-checking bench for sync_parallel_counter (size=3, init_value=2),
// directed scenarios followed by a randomized run against a mod-8 model.
module tb_sync_parallel_counter;

    localparam int SIZE = 3;
    localparam int INIT = 2;
    localparam int MODN = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            load = 1'b0;
    logic [SIZE-1:0] load_value = '0;
    logic            inc_enable = 1'b0;
    logic            dec_enable = 1'b0;
    logic [SIZE-1:0] value;
`ifdef SYNC_PARALLEL_COUNTER_FLAGS_EN
    logic            wrap_up;
    logic            wrap_down;
`endif

    int pass_count  = 0;
    int check_count = 0;

    sync_parallel_counter #(
        .size      (SIZE),
        .init_value(INIT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .inc_enable (inc_enable),
        .dec_enable (dec_enable),
`ifdef SYNC_PARALLEL_COUNTER_FLAGS_EN
        .wrap_up    (wrap_up),
        .wrap_down  (wrap_down),
`endif
        .value      (value)
    );

    always #5 clock = ~clock;

    // One rising edge; returns at the following falling edge where inputs change and outputs are sampled.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic ld, input int lv, input logic inc, input logic dec);
        load       = ld;
        load_value = SIZE'(lv);
        inc_enable = inc;
        dec_enable = dec;
    endtask

    task automatic test_reset();
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check_count++;
        if (value !== SIZE'(INIT))
            $display("FAIL reset_async: value=%0d expected=%0d", value, INIT);
        else pass_count++;
        drive(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_count++;
            if (value !== SIZE'(INIT))
                $display("FAIL reset_hold[%0d]: value=%0d expected=%0d", i, value, INIT);
            else pass_count++;
        end
`ifdef SYNC_PARALLEL_COUNTER_FLAGS_EN
        check_count++;
        if (wrap_up !== 1'b0 || wrap_down !== 1'b0)
            $display("FAIL reset_flags: wrap_up=%0b wrap_down=%0b expected=0/0", wrap_up, wrap_down);
        else pass_count++;
`endif
        drive(1'b0, 0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        $display("test_reset: value=%0d", value);
    endtask

    task automatic test_inc_wrap();
        int exp_val[3] = '{7, 0, 1};
        logic exp_wu[3] = '{1'b0, 1'b1, 1'b0};
        drive(1'b1, 6, 1'b0, 1'b0);
        step();
        drive(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_count++;
            if (value !== SIZE'(exp_val[i]))
                $display("FAIL inc_wrap[%0d]: value=%0d expected=%0d", i, value, exp_val[i]);
            else pass_count++;
`ifdef SYNC_PARALLEL_COUNTER_FLAGS_EN
            check_count++;
            if (wrap_up !== exp_wu[i] || wrap_down !== 1'b0)
                $display("FAIL inc_wrap_flag[%0d]: wrap_up=%0b wrap_down=%0b expected=%0b/0",
                         i, wrap_up, wrap_down, exp_wu[i]);
            else pass_count++;
`else
            if (exp_wu[i] === 1'bx) $display("unreachable");
`endif
            $display("test_inc_wrap: edge %0d value=%0d", i, value);
        end
        drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_dec_wrap();
        int exp_val[2] = '{0, 7};
        logic exp_wd[2] = '{1'b0, 1'b1};
        drive(1'b1, 1, 1'b0, 1'b0);
        step();
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            check_count++;
            if (value !== SIZE'(exp_val[i]))
                $display("FAIL dec_wrap[%0d]: value=%0d expected=%0d", i, value, exp_val[i]);
            else pass_count++;
`ifdef SYNC_PARALLEL_COUNTER_FLAGS_EN
            check_count++;
            if (wrap_down !== exp_wd[i] || wrap_up !== 1'b0)
                $display("FAIL dec_wrap_flag[%0d]: wrap_down=%0b wrap_up=%0b expected=%0b/0",
                         i, wrap_down, wrap_up, exp_wd[i]);
            else pass_count++;
`else
            if (exp_wd[i] === 1'bx) $display("unreachable");
`endif
            $display("test_dec_wrap: edge %0d value=%0d", i, value);
        end
        drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_load_priority();
        drive(1'b1, 3, 1'b0, 1'b0);
        step();
        drive(1'b1, 5, 1'b1, 1'b1);
        step();
        check_count++;
        if (value !== SIZE'(5))
            $display("FAIL load_priority: value=%0d expected=5", value);
        else pass_count++;
`ifdef SYNC_PARALLEL_COUNTER_FLAGS_EN
        check_count++;
        if (wrap_up !== 1'b0 || wrap_down !== 1'b0)
            $display("FAIL load_flags: wrap_up=%0b wrap_down=%0b expected=0/0", wrap_up, wrap_down);
        else pass_count++;
`endif
        $display("test_load_priority: value=%0d", value);
        drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 4, 1'b0, 1'b0);
        step();
        drive(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            check_count++;
            if (value !== SIZE'(4))
                $display("FAIL simultaneous[%0d]: value=%0d expected=4", i, value);
            else pass_count++;
        end
        $display("test_simultaneous: value=%0d", value);
        drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int   model = 0;
        logic exp_wu, exp_wd;
        logic r, ld, inc, dec;
        int   lv;
        // Resynchronise the model with a known load.
        drive(1'b1, 0, 1'b0, 1'b0);
        step();
        model = 0;
        for (int n = 0; n < 1000; n++) begin
            r   = ($urandom_range(0, 19) == 0);
            ld  = ($urandom_range(0, 3) == 0);
            lv  = int'($urandom_range(0, MODN - 1));
            inc = 1'($urandom);
            dec = 1'($urandom);
            drive(ld, lv, inc, dec);
            reset = r;
            exp_wu = 1'b0;
            exp_wd = 1'b0;
            if (r) begin
                #1;
                check_count++;
                if (value !== SIZE'(INIT))
                    $display("FAIL rand_async_reset[%0d]: value=%0d expected=%0d", n, value, INIT);
                else pass_count++;
                model = INIT;
            end else if (ld) begin
                model = lv;
            end else begin
                exp_wu = inc && !dec && (model == MODN - 1);
                exp_wd = dec && !inc && (model == 0);
                model  = (model + int'(inc) - int'(dec) + MODN) % MODN;
            end
            step();
            check_count++;
            if (value !== SIZE'(model))
                $display("FAIL rand_value[%0d]: value=%0d expected=%0d", n, value, model);
            else pass_count++;
`ifdef SYNC_PARALLEL_COUNTER_FLAGS_EN
            check_count++;
            if (wrap_up !== exp_wu || wrap_down !== exp_wd)
                $display("FAIL rand_flags[%0d]: wrap_up=%0b wrap_down=%0b expected=%0b/%0b",
                         n, wrap_up, wrap_down, exp_wu, exp_wd);
            else pass_count++;
`endif
            $display("rand[%0d]: rst=%0b ld=%0b lv=%0d inc=%0b dec=%0b -> value=%0d model=%0d flags=%0b%0b",
                     n, r, ld, lv, inc, dec, value, model, exp_wu, exp_wd);
        end
        reset = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_inc_wrap();
        test_dec_wrap();
        test_load_priority();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/sync_parallel_counter.md
SYNC_PARALLEL_COUNTER -- requirements
Module: sync_parallel_counter

Interface
REQ-001 The block SHALL have parameter size, default 4, giving the counter width in bits (size >= 1).
REQ-002 The block SHALL have parameter init_value, default 0, giving the value loaded on reset (0 <= init_value < 2^size).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port load, input, 1 bit: parallel-load request.
REQ-006 The block SHALL have port load_value, input, size bits: the value written by a load.
REQ-007 The block SHALL have port inc_enable, input, 1 bit: count-up request.
REQ-008 The block SHALL have port dec_enable, input, 1 bit: count-down request.
REQ-009 The block SHALL have port value, output, size bits: the registered counter state.

Function
REQ-010 value SHALL be driven directly from the state register, with no combinational path from any input to value.
REQ-011 Each rising clock edge with reset low SHALL apply exactly one update, by priority: load, then inc/dec.
REQ-012 If load=1, the next value SHALL be load_value, regardless of inc_enable and dec_enable.
REQ-013 If load=0, inc_enable=1 and dec_enable=0, the next value SHALL be (value+1) mod 2^size; 2^size-1 wraps to 0.
REQ-014 If load=0, inc_enable=0 and dec_enable=1, the next value SHALL be (value-1) mod 2^size; 0 wraps to 2^size-1.
REQ-015 If load=0 and inc_enable=dec_enable=1, value SHALL hold, since the net change is zero.
REQ-016 If load, inc_enable and dec_enable are all 0, value SHALL hold.
REQ-017 The counter SHALL be synchronous-parallel: all bits update on the same edge, with no ripple clocking.
REQ-018 The next-state logic SHALL be purely combinational in value, load, load_value, inc_enable and dec_enable.

Reset
REQ-019 While reset=1, value SHALL equal init_value immediately (asynchronous) and SHALL ignore clock, load, inc_enable and dec_enable.
REQ-020 Reset asserted mid-operation SHALL override any pending load, increment or decrement.
REQ-021 After reset deasserts, the first rising edge SHALL apply the normal update rules starting from init_value.
REQ-022 With SYNC_PARALLEL_COUNTER_FLAGS_EN defined, both flags SHALL be 0 during reset.

Configuration
REQ-023 Macro SYNC_PARALLEL_COUNTER_FLAGS_EN, when defined, SHALL add two 1-bit registered outputs, wrap_up and wrap_down.
REQ-024 wrap_up SHALL pulse high for one cycle after an increment from 2^size-1 to 0.
REQ-025 wrap_down SHALL pulse high for one cycle after a decrement from 0 to 2^size-1.
REQ-026 Neither flag SHALL assert on a load, a hold, or a simultaneous inc/dec.
REQ-027 When SYNC_PARALLEL_COUNTER_FLAGS_EN is not defined, the flag ports and their logic SHALL be absent and behaviour SHALL be per REQ-001..REQ-021.

Structure
REQ-028 Shared package sync_parallel_counter_pkg SHALL hold the update-mode encoding (HOLD, LOAD, INC, DEC) as a typedef enum.
REQ-029 sync_parallel_counter_pkg SHALL hold the default width and init constants.
REQ-030 The combinational next-state and wrap-detect logic SHALL be one sub-module, sync_parallel_counter_next.
REQ-031 The top module SHALL hold only the state register and, if configured, the flag registers.

Verification (size=3, init_value=2)
REQ-032 Test reset: assert reset between edges -> value=2 with no clock edge; hold reset with inc_enable=1 over several edges -> value stays 2.
REQ-033 Test increment wrap: from value=6, inc_enable=1 for 3 edges -> 7, 0, 1; with FLAGS_EN, wrap_up=1 only in the cycle after 7->0.
REQ-034 Test decrement wrap: from value=1, dec_enable=1 for 2 edges -> 0, 7; with FLAGS_EN, wrap_down=1 only after 0->7.
REQ-035 Test load priority: value=3, load=1, load_value=5, inc_enable=dec_enable=1 -> value=5 and no flag.
REQ-036 Test simultaneous inc/dec: value=4, inc_enable=dec_enable=1, load=0 -> value stays 4.
REQ-037 Test random regression: 1000 cycles of random reset, load, load_value, inc_enable and dec_enable checked against a mod-8 reference model.
